l1a_blk_rdout_ctrl: RTL and testbench
=====================================

// Module: l1a_blk_rdout_ctrl
// PURPOSE
//  Readout sequencer for the L1A block FIFO. Pops one entry per L1A, emits an event header,
//  drives 1-2 SCA block conversion requests to the digitizer, then releases used blocks to
//  the SCA block manager. Sits between the L1A block FIFO and the ADC/readout-FIFO path.
// PARAMETERS
//  EVT_W   12    width of event counter EVT_CNT
//  TO_W    10    width of conversion-ack timeout counter (used only with macro below)
//  TO_MAX  1000  cycles without CONV_ACK before timeout (used only with macro below)
// PORTS
//  CLK        in   1     system clock
//  RST        in   1     reset, asynchronous, active-high
//  EN         in   1     1 = may start new events; 0 = finish current event, then hold in IDLE
//  F_EMPTY    in   1     L1A block FIFO empty
//  F_POP      out  1     L1A block FIFO pop (one-cycle pulse)
//  F_BLK      in   4     head entry: SCA block number
//  F_L1P      in   8     head entry: L1A pointer
//  F_OVFL     in   1     head entry: SCA full at L1A (no blocks allocated)
//  F_SCND_SH  in   1     head entry: second block shared with following event
//  F_SCND_BLK in   1     head entry: event spans two blocks
//  F_LCT_PH   in   1     head entry: LCT phase
//  HDR_VLD    out  1     header valid; held until HDR_RDY
//  HDR_RDY    in   1     header accepted
//  HDR_DATA   out  16    {EVT_CNT[3:0], F_L1P, 1'b0, OVFL, LCT_PH, TOERR}
//  CONV_REQ   out  1     conversion request; held until CONV_ACK
//  CONV_BLK   out  4     block to convert; stable while CONV_REQ high
//  CONV_ACK   in   1     conversion accepted
//  FREE_STB   out  1     one-cycle pulse: release block FREE_BLK to SCA manager
//  FREE_BLK   out  4     block being released
//  EVT_DONE   out  1     one-cycle pulse at end of each event
//  EVT_CNT    out  EVT_W events completed, wraps at 2^EVT_W
//  BUSY       out  1     high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, EVT_CNT=0, state IDLE; RST mid-event aborts instantly, no pop, no free.
//  FIFO read latency: head data valid 2 cycles after EMPTY falls or after a POP; hence SETTLE.
//  IDLE   : EN & !F_EMPTY -> SETTLE.
//  SETTLE : 1 cycle -> LATCH.
//  LATCH  : capture head fields into regs, F_POP=1 for this cycle -> HDR.
//  HDR    : HDR_VLD=1, HDR_DATA from captured regs; on HDR_RDY -> DONE if OVFL else CONV1.
//  CONV1  : CONV_REQ=1, CONV_BLK=BLK; on CONV_ACK -> FREE1.
//  FREE1  : FREE_STB, FREE_BLK=BLK -> CONV2 if SCND_BLK else DONE.
//  CONV2  : CONV_REQ=1, CONV_BLK=BLK+1 (mod 16); on CONV_ACK -> FREE2 if !SCND_SH else DONE.
//  FREE2  : FREE_STB, FREE_BLK=BLK+1 -> DONE.
//  DONE   : EVT_DONE=1, EVT_CNT+=1 -> IDLE (next event earliest SETTLE 1 cycle later).
//  Handshakes: REQ/VLD asserted registered, drop the cycle after ACK/RDY sampled high; ACK/RDY
//   while REQ/VLD low ignored. CONV_REQ deasserts for >=1 cycle between CONV1 and CONV2.
//  OVFL events: header only, no conversion, no free, still counted.
//  EN falling mid-event: event completes normally; new event not started.
//  F_EMPTY rising during SETTLE (not possible by FIFO contract): return to IDLE, no pop.
// CONFIGURATION
//  `L1A_RDOUT_TIMEOUT_EN defined: TO_W counter runs in CONV1/CONV2, cleared on state entry;
//   reaching TO_MAX drops CONV_REQ, skips remaining conversions and frees of the event, sets a
//   sticky TOERR reported in HDR_DATA[0] of the next header (cleared when that header sent),
//   -> DONE. Undefined: no counter, waits forever for CONV_ACK, HDR_DATA[0]=0.
// STRUCTURE
//  Package cfeb_rdout_pkg: state enum (IDLE,SETTLE,LATCH,HDR,CONV1,FREE1,CONV2,FREE2,DONE),
//   HDR_DATA field bit positions, block-number width 4.
//  Event counter reuses the existing cbnce counter (Width=EVT_W); no other sub-module.
// TESTING
//  1 single entry {BLK=3,L1P=8'h5A,SCND=0,OVFL=0}: one POP, header L1P=5A, CONV_BLK=3, FREE 3,
//    EVT_CNT 0->1.
//  2 SCND_BLK=1,SCND_SH=0,BLK=15: CONV 15 then 0 (wrap), FREE 15 then 0.
//  3 SCND_BLK=1,SCND_SH=1,BLK=6: CONV 6,7; only FREE 6.
//  4 OVFL=1: header bit OVFL=1, no CONV_REQ, no FREE_STB, EVT_DONE pulse.
//  5 3 back-to-back entries with HDR_RDY/CONV_ACK delayed 0..7 cycles random: 3 POPs, order and
//    data match push order, REQ stable until ACK.
//  6 RST asserted in CONV1: outputs 0 same cycle; timeout build: hold CONV_ACK=0 -> REQ drops at
//    TO_MAX, next header TOERR=1.

Source files
------------

// File: rtl/cfeb_rdout_pkg.sv
// Shared types and constants for the L1A block readout sequencer.
// Holds the FSM state encoding and header field positions.
package cfeb_rdout_pkg;

    localparam int BLK_W = 4;

    localparam int HDR_W        = 16;
    localparam int HDR_TOERR    = 0;
    localparam int HDR_LCT      = 1;
    localparam int HDR_OVFL     = 2;
    localparam int HDR_RSV      = 3;
    localparam int HDR_L1P_LSB  = 4;
    localparam int HDR_L1P_W    = 8;
    localparam int HDR_EVT_LSB  = 12;
    localparam int HDR_EVT_W    = 4;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        SETTLE = 4'd1,
        LATCH  = 4'd2,
        HDR    = 4'd3,
        CONV1  = 4'd4,
        FREE1  = 4'd5,
        CONV2  = 4'd6,
        FREE2  = 4'd7,
        DONE   = 4'd8
    } state_t;

    // Second block of an event is the next SCA block, wrapping at 16.
    function automatic logic [BLK_W-1:0] blk_inc(input logic [BLK_W-1:0] b);
        return b + 1'b1;
    endfunction

endpackage

// File: rtl/cbnce.sv
// Binary counter with clock enable and asynchronous active-high reset.
// Wraps naturally at 2^Width.
module cbnce #(
    parameter int Width = 12
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    output logic [Width-1:0] Q
);

    // Count up by one on every enabled cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q <= '0;
        end else if (CE) begin
            Q <= Q + 1'b1;
        end
    end

endmodule

// File: rtl/l1a_blk_rdout_ctrl.sv
// L1A block FIFO readout sequencer: header, 1-2 SCA conversions, block release.
// Optional macro L1A_RDOUT_TIMEOUT_EN adds a conversion-ack timeout with sticky TOERR.
module l1a_blk_rdout_ctrl
    import cfeb_rdout_pkg::*;
#(
    parameter int EVT_W  = 12,
    parameter int TO_W   = 10,
    parameter int TO_MAX = 1000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             F_EMPTY,
    output logic             F_POP,
    input  logic [3:0]       F_BLK,
    input  logic [7:0]       F_L1P,
    input  logic             F_OVFL,
    input  logic             F_SCND_SH,
    input  logic             F_SCND_BLK,
    input  logic             F_LCT_PH,
    output logic             HDR_VLD,
    input  logic             HDR_RDY,
    output logic [15:0]      HDR_DATA,
    output logic             CONV_REQ,
    output logic [3:0]       CONV_BLK,
    input  logic             CONV_ACK,
    output logic             FREE_STB,
    output logic [3:0]       FREE_BLK,
    output logic             EVT_DONE,
    output logic [EVT_W-1:0] EVT_CNT,
    output logic             BUSY
);

    if (TO_MAX < 1 || TO_MAX >= (1 << TO_W)) begin : g_bad_to
        $error("TO_MAX does not fit in TO_W bits");
    end

    state_t state_q;
    state_t state_d;

    logic [BLK_W-1:0]     blk_q;
    logic [HDR_L1P_W-1:0] l1p_q;
    logic                 ovfl_q;
    logic                 sh_q;
    logic                 scnd_q;
    logic                 lct_q;
    logic                 toerr_q;
    logic                 to_hit;
    logic [HDR_W-1:0]     hdr_word;

    // State register; reset aborts any event in progress.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the FIFO head fields in the cycle the entry is popped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blk_q  <= '0;
            l1p_q  <= '0;
            ovfl_q <= 1'b0;
            sh_q   <= 1'b0;
            scnd_q <= 1'b0;
            lct_q  <= 1'b0;
        end else if (state_q == LATCH) begin
            blk_q  <= F_BLK;
            l1p_q  <= F_L1P;
            ovfl_q <= F_OVFL;
            sh_q   <= F_SCND_SH;
            scnd_q <= F_SCND_BLK;
            lct_q  <= F_LCT_PH;
        end
    end

`ifdef L1A_RDOUT_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            conv_st;

    assign conv_st = (state_q == CONV1) || (state_q == CONV2);
    assign to_hit  = conv_st && !CONV_ACK
                   && (to_cnt == TO_W'(TO_MAX - 1));

    // Cycles spent waiting for CONV_ACK, restarted on every state change.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            to_cnt <= '0;
        end else if (!conv_st || (state_d != state_q)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, reported and cleared by the next header.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            toerr_q <= 1'b0;
        end else if (to_hit) begin
            toerr_q <= 1'b1;
        end else if ((state_q == HDR) && HDR_RDY) begin
            toerr_q <= 1'b0;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign toerr_q = 1'b0;
`endif

    // Assemble the event header from the captured fields.
    always_comb begin
        hdr_word = '0;
        hdr_word[HDR_EVT_LSB +: HDR_EVT_W] = EVT_CNT[HDR_EVT_W-1:0];
        hdr_word[HDR_L1P_LSB +: HDR_L1P_W] = l1p_q;
        hdr_word[HDR_RSV]   = 1'b0;
        hdr_word[HDR_OVFL]  = ovfl_q;
        hdr_word[HDR_LCT]   = lct_q;
        hdr_word[HDR_TOERR] = toerr_q;
    end

    // Next-state and Moore outputs decoded from the state register.
    always_comb begin
        state_d  = state_q;
        F_POP    = 1'b0;
        HDR_VLD  = 1'b0;
        HDR_DATA = '0;
        CONV_REQ = 1'b0;
        CONV_BLK = '0;
        FREE_STB = 1'b0;
        FREE_BLK = '0;
        EVT_DONE = 1'b0;
        BUSY     = 1'b1;
        unique case (state_q)
            IDLE: begin
                BUSY = 1'b0;
                if (EN && !F_EMPTY) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                state_d = F_EMPTY ? IDLE : LATCH;
            end
            LATCH: begin
                F_POP   = 1'b1;
                state_d = HDR;
            end
            HDR: begin
                HDR_VLD  = 1'b1;
                HDR_DATA = hdr_word;
                if (HDR_RDY) begin
                    state_d = ovfl_q ? DONE : CONV1;
                end
            end
            CONV1: begin
                CONV_REQ = 1'b1;
                CONV_BLK = blk_q;
                if (CONV_ACK) begin
                    state_d = FREE1;
                end else if (to_hit) begin
                    state_d = DONE;
                end
            end
            FREE1: begin
                FREE_STB = 1'b1;
                FREE_BLK = blk_q;
                state_d  = scnd_q ? CONV2 : DONE;
            end
            CONV2: begin
                CONV_REQ = 1'b1;
                CONV_BLK = blk_inc(blk_q);
                if (CONV_ACK) begin
                    state_d = sh_q ? DONE : FREE2;
                end else if (to_hit) begin
                    state_d = DONE;
                end
            end
            FREE2: begin
                FREE_STB = 1'b1;
                FREE_BLK = blk_inc(blk_q);
                state_d  = DONE;
            end
            DONE: begin
                EVT_DONE = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    cbnce #(
        .Width (EVT_W)
    ) u_evt_cnt (
        .CLK (CLK),
        .RST (RST),
        .CE  (state_q == DONE),
        .Q   (EVT_CNT)
    );

endmodule

// File: tb/tb_l1a_blk_rdout_ctrl.sv
// Self-checking bench for l1a_blk_rdout_ctrl with a FIFO model and scoreboard.
// Define L1A_RDOUT_TIMEOUT_EN to also exercise the conversion-ack timeout.
module tb_l1a_blk_rdout_ctrl;

    localparam int EVT_W  = 12;
    localparam int TO_W   = 10;
    localparam int TO_MAX = 1000;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             EN = 1'b0;
    logic             F_EMPTY = 1'b1;
    logic             F_POP;
    logic [3:0]       F_BLK = '0;
    logic [7:0]       F_L1P = '0;
    logic             F_OVFL = 1'b0;
    logic             F_SCND_SH = 1'b0;
    logic             F_SCND_BLK = 1'b0;
    logic             F_LCT_PH = 1'b0;
    logic             HDR_VLD;
    logic             HDR_RDY = 1'b0;
    logic [15:0]      HDR_DATA;
    logic             CONV_REQ;
    logic [3:0]       CONV_BLK;
    logic             CONV_ACK = 1'b0;
    logic             FREE_STB;
    logic [3:0]       FREE_BLK;
    logic             EVT_DONE;
    logic [EVT_W-1:0] EVT_CNT;
    logic             BUSY;

    always #5 CLK = ~CLK;

    l1a_blk_rdout_ctrl #(
        .EVT_W  (EVT_W),
        .TO_W   (TO_W),
        .TO_MAX (TO_MAX)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .F_EMPTY    (F_EMPTY),
        .F_POP      (F_POP),
        .F_BLK      (F_BLK),
        .F_L1P      (F_L1P),
        .F_OVFL     (F_OVFL),
        .F_SCND_SH  (F_SCND_SH),
        .F_SCND_BLK (F_SCND_BLK),
        .F_LCT_PH   (F_LCT_PH),
        .HDR_VLD    (HDR_VLD),
        .HDR_RDY    (HDR_RDY),
        .HDR_DATA   (HDR_DATA),
        .CONV_REQ   (CONV_REQ),
        .CONV_BLK   (CONV_BLK),
        .CONV_ACK   (CONV_ACK),
        .FREE_STB   (FREE_STB),
        .FREE_BLK   (FREE_BLK),
        .EVT_DONE   (EVT_DONE),
        .EVT_CNT    (EVT_CNT),
        .BUSY       (BUSY)
    );

    typedef struct packed {
        logic [3:0] blk;
        logic [7:0] l1p;
        logic       ovfl;
        logic       sh;
        logic       scnd;
        logic       lct;
    } ent_t;

    ent_t        fifo_q[$];
    logic [15:0] exp_hdr[$];
    logic [3:0]  exp_conv[$];
    logic [3:0]  exp_free[$];

    int   n_chk = 0;
    int   n_err = 0;
    int   push_evt = 0;
    int   exp_evt = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   hdr_dly = 0;
    int   conv_dly = 0;
    bit   pop_pend = 0;
    bit   ack_hold = 0;
    bit   hdr_held = 0;
    bit   conv_held = 0;
    bit   done_prev = 0;
    logic toerr_next = 1'b0;
    logic [15:0] hdr_seen = '0;
    logic [3:0]  conv_seen = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] blk, input logic [7:0] l1p,
                        input logic ovfl, input logic sh, input logic scnd,
                        input logic lct, input bit to_skip);
        ent_t       e;
        logic [3:0] b2;
        e.blk  = blk;
        e.l1p  = l1p;
        e.ovfl = ovfl;
        e.sh   = sh;
        e.scnd = scnd;
        e.lct  = lct;
        b2     = blk + 4'd1;
        fifo_q.push_back(e);
        exp_hdr.push_back({4'(push_evt), l1p, 1'b0, ovfl, lct, toerr_next});
        toerr_next = 1'b0;
        if (!ovfl && !to_skip) begin
            exp_conv.push_back(blk);
            exp_free.push_back(blk);
            if (scnd) begin
                exp_conv.push_back(b2);
                if (!sh) exp_free.push_back(b2);
            end
        end
        push_evt++;
        n_push++;
    endtask

    // One clock: FIFO model, responders and output monitors, all at negedge.
    task automatic step();
        ent_t h;
        @(negedge CLK);
        if (pop_pend) begin
            if (fifo_q.size() > 0) h = fifo_q.pop_front();
            pop_pend = 0;
        end
        if (F_POP) begin
            n_pop++;
            pop_pend = 1;
        end
        F_EMPTY = (fifo_q.size() == 0);
        if (!F_EMPTY) begin
            h          = fifo_q[0];
            F_BLK      = h.blk;
            F_L1P      = h.l1p;
            F_OVFL     = h.ovfl;
            F_SCND_SH  = h.sh;
            F_SCND_BLK = h.scnd;
            F_LCT_PH   = h.lct;
        end
        if (HDR_RDY) begin
            chk("hdr_drop", 32'(HDR_VLD), 32'd0);
            chk("hdr_expected", 32'(exp_hdr.size() > 0), 32'd1);
            if (exp_hdr.size() > 0)
                chk("hdr_data", 32'(hdr_seen), 32'(exp_hdr.pop_front()));
            HDR_RDY  = 1'b0;
            hdr_held = 0;
            hdr_dly  = int'($urandom_range(0, 7));
        end else if (HDR_VLD) begin
            if (hdr_held) chk("hdr_stable", 32'(HDR_DATA), 32'(hdr_seen));
            hdr_seen = HDR_DATA;
            hdr_held = 1;
            if (hdr_dly == 0) HDR_RDY = 1'b1;
            else hdr_dly--;
        end else begin
            hdr_held = 0;
        end
        if (CONV_ACK) begin
            chk("conv_drop", 32'(CONV_REQ), 32'd0);
            chk("conv_expected", 32'(exp_conv.size() > 0), 32'd1);
            if (exp_conv.size() > 0)
                chk("conv_blk", 32'(conv_seen), 32'(exp_conv.pop_front()));
            CONV_ACK  = 1'b0;
            conv_held = 0;
            conv_dly  = int'($urandom_range(0, 7));
        end else if (CONV_REQ) begin
            if (conv_held) chk("conv_stable", 32'(CONV_BLK), 32'(conv_seen));
            conv_seen = CONV_BLK;
            conv_held = 1;
            if (!ack_hold) begin
                if (conv_dly == 0) CONV_ACK = 1'b1;
                else conv_dly--;
            end
        end else begin
            conv_held = 0;
        end
        if (FREE_STB) begin
            chk("free_expected", 32'(exp_free.size() > 0), 32'd1);
            if (exp_free.size() > 0)
                chk("free_blk", 32'(FREE_BLK), 32'(exp_free.pop_front()));
        end
        if (EVT_DONE) begin
            chk("done_pulse", 32'(done_prev), 32'd0);
            chk("evt_cnt", 32'(EVT_CNT), 32'(exp_evt % (1 << EVT_W)));
            exp_evt++;
        end
        done_prev = EVT_DONE;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(fifo_q.size() == 0 && !pop_pend && !BUSY
                     && exp_evt == push_evt) && n < budget);
        chk("drain_events", 32'(exp_evt), 32'(push_evt));
        chk("drain_busy", 32'(BUSY), 32'd0);
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (!CONV_REQ && n < budget) begin
            step();
            n++;
        end
        chk("conv_reached", 32'(CONV_REQ), 32'd1);
    endtask

    initial begin
        int pops0;
        int cnt;
        repeat (3) step();
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_hdr_vld", 32'(HDR_VLD), 32'd0);
        chk("rst_conv_req", 32'(CONV_REQ), 32'd0);
        chk("rst_pop", 32'(F_POP), 32'd0);
        chk("rst_evt_cnt", 32'(EVT_CNT), 32'd0);
        RST = 1'b0;
        EN  = 1'b1;
        step();

        push(4'd3, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        drain(200);
        chk("t1_evt_cnt", 32'(EVT_CNT), 32'd1);
        chk("t1_pops", 32'(n_pop), 32'd1);

        push(4'd15, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        drain(200);
        push(4'd6, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        drain(200);
        push(4'd9, 8'hE7, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        drain(200);

        for (int i = 0; i < 3; i++)
            push(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        drain(400);
        chk("t5_pops", 32'(n_pop), 32'(n_push));

        EN = 1'b0;
        pops0 = n_pop;
        push(4'd1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        repeat (20) step();
        chk("en_hold_busy", 32'(BUSY), 32'd0);
        chk("en_hold_pop", 32'(n_pop), 32'(pops0));
        EN = 1'b1;
        drain(200);

        push(4'd12, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        cnt = 0;
        while (!HDR_VLD && cnt < 50) begin
            step();
            cnt++;
        end
        EN = 1'b0;
        drain(200);
        EN = 1'b1;

        ack_hold = 1;
        push(4'd4, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        wait_req(100);
        #2 RST = 1'b1;
        #1;
        chk("rst_mid_req", 32'(CONV_REQ), 32'd0);
        chk("rst_mid_busy", 32'(BUSY), 32'd0);
        chk("rst_mid_free", 32'(FREE_STB), 32'd0);
        chk("rst_mid_cnt", 32'(EVT_CNT), 32'd0);
        fifo_q.delete();
        exp_hdr.delete();
        exp_conv.delete();
        exp_free.delete();
        pop_pend  = 0;
        HDR_RDY   = 1'b0;
        CONV_ACK  = 1'b0;
        hdr_held  = 0;
        conv_held = 0;
        push_evt  = 0;
        exp_evt   = 0;
        ack_hold  = 0;
        repeat (2) step();
        RST = 1'b0;
        push(4'd8, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        drain(200);
        chk("post_rst_cnt", 32'(EVT_CNT), 32'd1);

`ifdef L1A_RDOUT_TIMEOUT_EN
        ack_hold = 1;
        push(4'd10, 8'hAB, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        wait_req(100);
        cnt = 1;
        while (cnt < TO_MAX + 200) begin
            step();
            if (!CONV_REQ) break;
            cnt++;
        end
        chk("to_req_len", 32'(cnt), 32'(TO_MAX));
        ack_hold = 0;
        drain(200);
        toerr_next = 1'b1;
        push(4'd2, 8'hCD, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        drain(200);
        push(4'd5, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        drain(200);
`endif

        chk("end_hdr_q", 32'(exp_hdr.size()), 32'd0);
        chk("end_conv_q", 32'(exp_conv.size()), 32'd0);
        chk("end_free_q", 32'(exp_free.size()), 32'd0);
        chk("end_pops", 32'(n_pop), 32'(n_push));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
